// File: rtl/msk_demux_buf.sv
// Masked 1-to-2 demultiplexing buffer: routes a whole sharing into one of two
// single-entry output channels. Shares are never combined; only sel and the handshake steer.
module msk_demux_buf #(
   parameter int d     = 1,
   parameter int count = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               sel,
   input  logic [count*d-1:0] in_data,
   output logic               out0_valid,
   input  logic               out0_ready,
   output logic [count*d-1:0] out0_data,
   output logic               out1_valid,
   input  logic               out1_ready,
   output logic [count*d-1:0] out1_data,
   output logic               busy
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t        r_state0;
   chan_state_t        r_state1;
   chan_state_t        w_state0Next;
   chan_state_t        w_state1Next;
   logic [count*d-1:0] r_data0;
   logic [count*d-1:0] r_data1;
   logic               w_free0;
   logic               w_free1;
   logic               w_xfer;
   logic               w_load0;
   logic               w_load1;

   // A channel can take a sharing when it is empty or is being drained this cycle.
   assign w_free0  = (r_state0 == EMPTY) || out0_ready;
   assign w_free1  = (r_state1 == EMPTY) || out1_ready;
   assign in_ready = rst_n && (sel ? w_free1 : w_free0);
   assign w_xfer   = in_valid && in_ready;
   assign w_load0  = w_xfer && !sel;
   assign w_load1  = w_xfer && sel;

   always_comb begin
      w_state0Next = r_state0;
      w_state1Next = r_state1;
      if (w_load0) begin
         w_state0Next = FULL;
      end else if ((r_state0 == FULL) && out0_ready) begin
         w_state0Next = EMPTY;
      end
      if (w_load1) begin
         w_state1Next = FULL;
      end else if ((r_state1 == FULL) && out1_ready) begin
         w_state1Next = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state0 <= EMPTY;
         r_state1 <= EMPTY;
      end else begin
         r_state0 <= w_state0Next;
         r_state1 <= w_state1Next;
      end
   end

   // Data registers only move on a load; a pop leaves the stale sharing in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data0 <= '0;
         r_data1 <= '0;
      end else begin
         if (w_load0) begin
            r_data0 <= in_data;
         end
         if (w_load1) begin
            r_data1 <= in_data;
         end
      end
   end

   assign out0_valid = (r_state0 == FULL);
   assign out1_valid = (r_state1 == FULL);
   assign out0_data  = r_data0;
   assign out1_data  = r_data1;
   assign busy       = out0_valid || out1_valid;

endmodule

// File: tb/tb_msk_demux_buf.sv
// Bench for msk_demux_buf with d=2, count=1: directed vector table, reset
// corner cases, then randomized traffic against a per-channel queue model.
module tb_msk_demux_buf;

   logic       clk;
   logic       rst_n;
   logic       inValid;
   logic       inReady;
   logic       sel;
   logic [1:0] inData;
   logic       out0Valid;
   logic       out0Ready;
   logic [1:0] out0Data;
   logic       out1Valid;
   logic       out1Ready;
   logic [1:0] out1Data;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   msk_demux_buf #(.d(2), .count(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .sel        (sel),
      .in_data    (inData),
      .out0_valid (out0Valid),
      .out0_ready (out0Ready),
      .out0_data  (out0Data),
      .out1_valid (out1Valid),
      .out1_ready (out1Ready),
      .out1_data  (out1Data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sel;
      logic       iv;
      logic [1:0] data;
      logic       r0;
      logic       r1;
      logic       expIr;
      logic       expV0;
      logic [1:0] expD0;
      logic       expV1;
      logic [1:0] expD1;
      logic       expBusy;
   } vec_t;

   vec_t vecs[11];
   logic [1:0] q0[$];
   logic [1:0] q1[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic iv, input logic [1:0] data,
                                input logic r0, input logic r1);
      sel       = s;
      inValid   = iv;
      inData    = data;
      out0Ready = r0;
      out1Ready = r1;
   endtask

   initial begin
      logic expIr;
      // sel iv data r0 r1 | in_ready v0 d0 v1 d1 busy
      vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 2'b11, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b11, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 2'b10, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b10, 1'b1};

      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
      #12;
      checkOutput("reset_in_ready", inReady, 0);
      checkOutput("reset_out0_valid", out0Valid, 0);
      checkOutput("reset_out1_valid", out1Valid, 0);
      checkOutput("reset_busy", busy, 0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].sel, vecs[i].iv, vecs[i].data, vecs[i].r0, vecs[i].r1);
         #1;
         checkOutput($sformatf("v%0d_in_ready", i), inReady, vecs[i].expIr);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_out0_valid", i), out0Valid, vecs[i].expV0);
         checkOutput($sformatf("v%0d_out0_data", i), out0Data, vecs[i].expD0);
         checkOutput($sformatf("v%0d_out1_valid", i), out1Valid, vecs[i].expV1);
         checkOutput($sformatf("v%0d_out1_data", i), out1Data, vecs[i].expD1);
         checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].expBusy);
      end

      // Mid-cycle reset with out0 full: everything clears before the next edge.
      applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out0_valid", out0Valid, 0);
      checkOutput("midrst_out0_data", out0Data, 0);
      checkOutput("midrst_out1_data", out1Data, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_in_ready", inReady, 0);
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("inrst_out0_valid", out0Valid, 0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
      #1;
      checkOutput("postrst_in_ready", inReady, 1);
      @(posedge clk);
      #1;
      checkOutput("postrst_out0_valid", out0Valid, 1);
      checkOutput("postrst_out0_data", out0Data, 2'b10);
      checkOutput("postrst_out1_valid", out1Valid, 0);
      q0.push_back(2'b10);

      // Random traffic; each channel modeled as a queue holding at most one sharing.
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
         #1;
         expIr = sel ? ((q1.size() == 0) || out1Ready) : ((q0.size() == 0) || out0Ready);
         checkOutput("rnd_in_ready", inReady, expIr);
         checkOutput("rnd_out0_valid", out0Valid, q0.size() != 0);
         checkOutput("rnd_out1_valid", out1Valid, q1.size() != 0);
         checkOutput("rnd_busy", busy, (q0.size() != 0) || (q1.size() != 0));
         if (q0.size() != 0 && out0Ready) begin
            checkOutput("rnd_out0_data", out0Data, q0[0]);
            void'(q0.pop_front());
         end
         if (q1.size() != 0 && out1Ready) begin
            checkOutput("rnd_out1_data", out1Data, q1[0]);
            void'(q1.pop_front());
         end
         if (inValid && expIr) begin
            if (sel) q1.push_back(inData);
            else q0.push_back(inData);
         end
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
